// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from a first-word-fall-through TX FIFO and
// serialises them as start / data (LSB first) / optional parity / stop frames.
module uart_tx_engine #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_re,
    output logic                 txd,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t               state_r;
    logic [DIV_WIDTH-1:0] baud_cnt_r;
    logic [BW-1:0]        bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DIV_WIDTH-1:0] div_r;
    logic                 par_en_r;
    logic                 par_bit_r;
    logic                 stop2_r;
    logic                 txd_r;
    logic                 busy_r;
    logic                 pop_s;
    logic                 last_tick_s;
    logic                 last_data_s;
    logic                 final_stop_s;

    // Bit-period and bit-position boundaries, all from the latched frame settings
    assign last_tick_s  = (baud_cnt_r == div_r);
    assign last_data_s  = (bit_cnt_r == BW'(DATA_BITS - 1));
    assign final_stop_s = (bit_cnt_r == {{(BW-1){1'b0}}, stop2_r});

    assign fifo_re = pop_s;
    assign txd     = txd_r;
    assign busy    = busy_r;

    // Pop strobe: idle line, or the very last cycle of the final stop bit
    always_comb begin
        pop_s = 1'b0;
        if (reset || fifo_empty) begin
            pop_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            pop_s = 1'b1;
        end else if ((state_r == ST_STOP) && last_tick_s && final_stop_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Frame sequencer with registered line and busy outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {DIV_WIDTH{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
            div_r      <= {DIV_WIDTH{1'b0}};
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            stop2_r    <= 1'b0;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            // Configuration is frozen per frame at the pop
            if (pop_s) begin
                shift_r   <= fifo_data;
                div_r     <= divisor;
                par_en_r  <= parity_en;
                par_bit_r <= parity_bit(fifo_data, parity_odd);
                stop2_r   <= stop2;
            end
            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= {DIV_WIDTH{1'b0}};
                    bit_cnt_r  <= {BW{1'b0}};
                    if (pop_s) begin
                        state_r <= ST_START;
                        txd_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        txd_r  <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (last_tick_s) begin
                        baud_cnt_r <= {DIV_WIDTH{1'b0}};
                        bit_cnt_r  <= {BW{1'b0}};
                        state_r    <= ST_DATA;
                        txd_r      <= shift_r[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + DIV_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (last_tick_s) begin
                        baud_cnt_r <= {DIV_WIDTH{1'b0}};
                        if (last_data_s) begin
                            bit_cnt_r <= {BW{1'b0}};
                            if (par_en_r) begin
                                state_r <= ST_PARITY;
                                txd_r   <= par_bit_r;
                            end else begin
                                state_r <= ST_STOP;
                                txd_r   <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + DIV_WIDTH'(1);
                    end
                end
                ST_PARITY: begin
                    if (last_tick_s) begin
                        baud_cnt_r <= {DIV_WIDTH{1'b0}};
                        bit_cnt_r  <= {BW{1'b0}};
                        state_r    <= ST_STOP;
                        txd_r      <= 1'b1;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + DIV_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    if (last_tick_s) begin
                        baud_cnt_r <= {DIV_WIDTH{1'b0}};
                        if (final_stop_s) begin
                            bit_cnt_r <= {BW{1'b0}};
                            if (pop_s) begin
                                state_r <= ST_START;
                                txd_r   <= 1'b0;
                                busy_r  <= 1'b1;
                            end else begin
                                state_r <= ST_IDLE;
                                txd_r   <= 1'b1;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= {DIV_WIDTH{1'b0}};
                    bit_cnt_r  <= {BW{1'b0}};
                    txd_r      <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule
